multiplier_pipe: RTL and testbench

//  Parametrised pipelined multiplier: signed/unsigned per operation, valid and tag tracking, stall,
//  and an optional shift/round/saturate output stage. Adder-tree datapath; one product per cycle.

---
 rtl/multiplier_pipe_pkg.sv | 23 ++
 rtl/mult_round_sat.sv | 93 +++++++++
 rtl/multiplier_pipe.sv | 140 ++++++++++++++
 tb/tb_multiplier_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_pipe_pkg.sv
// Shared constant helpers for the pipelined multiplier: operand-width
// arithmetic used to size the partial-product tree and the output stage.
package multiplier_pipe_pkg;

  function automatic int min_f(input int lhs, input int rhs);
    return (lhs < rhs) ? lhs : rhs;
  endfunction

  function automatic int max_f(input int lhs, input int rhs);
    return (lhs > rhs) ? lhs : rhs;
  endfunction

  // Number of bits needed to represent value (0 for value 0).
  function automatic int bit_width_f(input int value);
    int w;
    w = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((value >> i) != 32'sd0) w = i + 32'sd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mult_round_sat.sv
// Output stage of the multiplier: arithmetic/logical right shift, optional
// round-half-away-from-zero, saturation to OUT_WIDTH, and the output register.
module mult_round_sat
  import multiplier_pipe_pkg::*;
#(
  parameter int P_W       = 20,
  parameter int OUT_SHIFT = 0,
  parameter int OUT_WIDTH = 20,
  parameter int ROUND     = 0
) (
  input  logic                 clk_i,
  input  logic                 reset_an_i,
  input  logic                 reset_i,
  input  logic                 stall_i,
  input  logic                 sgn_i,
  input  logic [P_W-1:0]       prod_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 sat_o
);

  // Two guard bits above the widest quantity keep the limits and the
  // rounding increment free of overflow.
  localparam int RW = max_f(P_W, OUT_WIDTH) + 32'sd2;
  localparam logic signed [RW-1:0] ONE_C  = {{(RW-1){1'b0}}, 1'b1};
  localparam logic signed [RW-1:0] SMAX_C = (ONE_C <<< (OUT_WIDTH-1)) - ONE_C;
  localparam logic signed [RW-1:0] SMIN_C = -(ONE_C <<< (OUT_WIDTH-1));
  localparam logic signed [RW-1:0] UMAX_C = (ONE_C <<< OUT_WIDTH) - ONE_C;

  logic signed [RW-1:0]  ext_s;
  logic signed [RW-1:0]  sh_s;
  logic signed [RW-1:0]  res_s;
  logic signed [RW-1:0]  max_s;
  logic signed [RW-1:0]  min_s;
  logic                  inc_s;
  logic [OUT_WIDTH-1:0]  data_d;
  logic [OUT_WIDTH-1:0]  data_q;
  logic                  sat_d;
  logic                  sat_q;

  assign ext_s = {{(RW-P_W){sgn_i & prod_i[P_W-1]}}, prod_i};
  assign sh_s  = ext_s >>> OUT_SHIFT;
  assign max_s = sgn_i ? SMAX_C : UMAX_C;
  assign min_s = SMIN_C;

  generate
    if ((ROUND != 32'sd0) && (OUT_SHIFT > 32'sd0)) begin : g_round
      localparam logic signed [RW-1:0] HALF_C = ONE_C <<< (OUT_SHIFT-1);
      logic signed [RW-1:0] drop_s;
      // sh_s is a floor; a negative value with exactly half dropped already
      // sits on the away-from-zero side, so it only moves up past half.
      assign drop_s = ext_s - (sh_s <<< OUT_SHIFT);
      assign inc_s  = ext_s[RW-1] ? (drop_s > HALF_C) : (drop_s >= HALF_C);
    end else begin : g_trunc
      assign inc_s = 1'b0;
    end
  endgenerate

  assign res_s = sh_s + {{(RW-1){1'b0}}, inc_s};

  // Clip the rounded value into the signed or unsigned OUT_WIDTH range.
  always_comb begin
    data_d = res_s[OUT_WIDTH-1:0];
    sat_d  = 1'b0;
    if (res_s > max_s) begin
      data_d = max_s[OUT_WIDTH-1:0];
      sat_d  = 1'b1;
    end else if (sgn_i && (res_s < min_s)) begin
      data_d = min_s[OUT_WIDTH-1:0];
      sat_d  = 1'b1;
    end else begin
      data_d = res_s[OUT_WIDTH-1:0];
      sat_d  = 1'b0;
    end
  end

  // Output register: cleared by either reset, frozen while stalled.
  always_ff @(posedge clk_i or negedge reset_an_i) begin
    if (!reset_an_i) begin
      data_q <= {OUT_WIDTH{1'b0}};
      sat_q  <= 1'b0;
    end else if (reset_i) begin
      data_q <= {OUT_WIDTH{1'b0}};
      sat_q  <= 1'b0;
    end else if (!stall_i) begin
      data_q <= data_d;
      sat_q  <= sat_d;
    end
  end

  assign data_o = data_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/multiplier_pipe.sv
// Pipelined signed/unsigned multiplier. The narrower operand selects partial
// products of the sign/zero-extended wider one; a registered adder tree sums
// them (one level per stage) and mult_round_sat forms the final result.
// valid/tag/signed travel alongside so results come out with fixed LATENCY.
module multiplier_pipe
  import multiplier_pipe_pkg::*;
#(
  parameter int A_WIDTH   = 10,
  parameter int B_WIDTH   = 10,
  parameter int TAG_WIDTH = 1,
  parameter int OUT_SHIFT = 0,
  parameter int OUT_WIDTH = 20,
  parameter int ROUND     = 0
) (
  input  logic                 clk_i,
  input  logic                 reset_an_i,
  input  logic                 reset_i,
  input  logic                 stall_i,
  input  logic                 valid_i,
  input  logic                 signed_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  input  logic [A_WIDTH-1:0]   data_a_i,
  input  logic [B_WIDTH-1:0]   data_b_i,
  output logic                 valid_o,
  output logic [TAG_WIDTH-1:0] tag_o,
  output logic [OUT_WIDTH-1:0] data_p_o,
  output logic                 sat_o
);

  localparam int MIN_W   = min_f(A_WIDTH, B_WIDTH);
  localparam int MAX_W   = max_f(A_WIDTH, B_WIDTH);
  localparam int P_W     = A_WIDTH + B_WIDTH;
  localparam int TREE    = max_f(32'sd1, bit_width_f(MIN_W - 32'sd1));
  localparam int LEAVES  = 32'sd1 << TREE;
  localparam int LATENCY = TREE + 32'sd1;

  logic [MIN_W-1:0] narrow_s;
  logic [MAX_W-1:0] wide_s;
  logic [P_W-1:0]   wide_ext_s;
  logic [P_W-1:0]   leaf_s [LEAVES];
  // Heap layout: node 1 is the root, children of n are 2n and 2n+1; indices
  // at or above LEAVES refer to the combinational leaves.
  logic [P_W-1:0]   node_d [1:LEAVES-1];
  logic [P_W-1:0]   node_q [1:LEAVES-1];

  logic [LATENCY-1:0]                valid_d;
  logic [LATENCY-1:0]                valid_q;
  logic [LATENCY-1:0][TAG_WIDTH-1:0] tag_d;
  logic [LATENCY-1:0][TAG_WIDTH-1:0] tag_q;
  logic [TREE-1:0]                   sgn_d;
  logic [TREE-1:0]                   sgn_q;

  generate
    if (A_WIDTH <= B_WIDTH) begin : g_a_narrow
      assign narrow_s = data_a_i;
      assign wide_s   = data_b_i;
    end else begin : g_b_narrow
      assign narrow_s = data_b_i;
      assign wide_s   = data_a_i;
    end
  endgenerate

  assign wide_ext_s = {{MIN_W{signed_i & wide_s[MAX_W-1]}}, wide_s};

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < MIN_W) begin : g_used
      logic [P_W-1:0] pp_s;
      assign pp_s = narrow_s[i] ? (wide_ext_s << i) : {P_W{1'b0}};
      if (i == MIN_W - 1) begin : g_msb
        // The narrow operand's MSB carries weight -2^(MIN_W-1) when signed.
        assign leaf_s[i] = signed_i ? ({P_W{1'b0}} - pp_s) : pp_s;
      end else begin : g_low
        assign leaf_s[i] = pp_s;
      end
    end else begin : g_unused
      assign leaf_s[i] = {P_W{1'b0}};
    end
  end

  for (genvar n = 1; n < LEAVES; n++) begin : g_node
    if (2 * n >= LEAVES) begin : g_from_leaf
      assign node_d[n] = leaf_s[2*n-LEAVES] + leaf_s[2*n+1-LEAVES];
    end else begin : g_from_node
      assign node_d[n] = node_q[2*n] + node_q[2*n+1];
    end

    // Tree node register: loads every unstalled cycle, no valid gating.
    always_ff @(posedge clk_i or negedge reset_an_i) begin
      if (!reset_an_i) begin
        node_q[n] <= {P_W{1'b0}};
      end else if (reset_i) begin
        node_q[n] <= {P_W{1'b0}};
      end else if (!stall_i) begin
        node_q[n] <= node_d[n];
      end
    end
  end

  // The signed flag only needs to reach the output stage, TREE cycles deep.
  assign valid_d = {valid_q[LATENCY-2:0], valid_i};
  assign tag_d   = {tag_q[LATENCY-2:0], tag_i};
  assign sgn_d   = TREE'({sgn_q, signed_i});

  // Sideband shift pipes kept in step with the datapath.
  always_ff @(posedge clk_i or negedge reset_an_i) begin
    if (!reset_an_i) begin
      valid_q <= {LATENCY{1'b0}};
      tag_q   <= {(LATENCY*TAG_WIDTH){1'b0}};
      sgn_q   <= {TREE{1'b0}};
    end else if (reset_i) begin
      valid_q <= {LATENCY{1'b0}};
      tag_q   <= {(LATENCY*TAG_WIDTH){1'b0}};
      sgn_q   <= {TREE{1'b0}};
    end else if (!stall_i) begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      sgn_q   <= sgn_d;
    end
  end

  mult_round_sat #(
    .P_W       (P_W),
    .OUT_SHIFT (OUT_SHIFT),
    .OUT_WIDTH (OUT_WIDTH),
    .ROUND     (ROUND)
  ) u_round_sat (
    .clk_i      (clk_i),
    .reset_an_i (reset_an_i),
    .reset_i    (reset_i),
    .stall_i    (stall_i),
    .sgn_i      (sgn_q[TREE-1]),
    .prod_i     (node_q[1]),
    .data_o     (data_p_o),
    .sat_o      (sat_o)
  );

  assign valid_o = valid_q[LATENCY-1];
  assign tag_o   = tag_q[LATENCY-1];

endmodule

// File: tb/tb_multiplier_pipe.sv
// Directed bench for multiplier_pipe: four configurations share one stimulus
// stream (8x8 exact, 8x12 and 12x8 exact, 8x8 shift/round/saturate to 8 bits).
module tb_multiplier_pipe;

  logic        clk_s    = 1'b0;
  logic        rst_an_s = 1'b1;
  logic        rst_s    = 1'b0;
  logic        stall_s  = 1'b0;
  logic        valid_s  = 1'b0;
  logic        sgn_s    = 1'b0;
  logic [1:0]  tag_s    = 2'd0;
  logic [7:0]  a8_s     = 8'd0;
  logic [7:0]  b8_s     = 8'd0;
  logic [11:0] a12_s    = 12'd0;
  logic [11:0] b12_s    = 12'd0;

  logic va_s, vb_s, vc_s, vd_s;
  logic sa_s, sb_s, sc_s, sd_s;
  logic [1:0]  ta_s, tb_s, tc_s, td_s;
  logic [15:0] pa_s;
  logic [19:0] pb_s, pd_s;
  logic [7:0]  pc_s;

  int total_s = 0;
  int bad_s   = 0;

  localparam logic [7:0] T4_A [7] = '{8'h0A, 8'h7F, 8'h80, 8'hF8, 8'hFB, 8'hFF, 8'h64};
  localparam logic [7:0] T4_B [7] = '{8'h03, 8'h7F, 8'h7F, 8'h03, 8'h04, 8'hFF, 8'h02};
  localparam logic       T4_S [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [7:0] T4_P [7] = '{8'h02, 8'h7F, 8'h80, 8'hFE, 8'hFF, 8'hFF, 8'h0D};
  localparam logic       T4_Q [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  always #5 clk_s = ~clk_s;

  multiplier_pipe #(.A_WIDTH(8), .B_WIDTH(8), .TAG_WIDTH(2), .OUT_SHIFT(0),
                    .OUT_WIDTH(16), .ROUND(0)) u_a (
    .clk_i(clk_s), .reset_an_i(rst_an_s), .reset_i(rst_s), .stall_i(stall_s),
    .valid_i(valid_s), .signed_i(sgn_s), .tag_i(tag_s), .data_a_i(a8_s), .data_b_i(b8_s),
    .valid_o(va_s), .tag_o(ta_s), .data_p_o(pa_s), .sat_o(sa_s));

  multiplier_pipe #(.A_WIDTH(8), .B_WIDTH(12), .TAG_WIDTH(2), .OUT_SHIFT(0),
                    .OUT_WIDTH(20), .ROUND(0)) u_b (
    .clk_i(clk_s), .reset_an_i(rst_an_s), .reset_i(rst_s), .stall_i(stall_s),
    .valid_i(valid_s), .signed_i(sgn_s), .tag_i(tag_s), .data_a_i(a8_s), .data_b_i(b12_s),
    .valid_o(vb_s), .tag_o(tb_s), .data_p_o(pb_s), .sat_o(sb_s));

  multiplier_pipe #(.A_WIDTH(12), .B_WIDTH(8), .TAG_WIDTH(2), .OUT_SHIFT(0),
                    .OUT_WIDTH(20), .ROUND(0)) u_d (
    .clk_i(clk_s), .reset_an_i(rst_an_s), .reset_i(rst_s), .stall_i(stall_s),
    .valid_i(valid_s), .signed_i(sgn_s), .tag_i(tag_s), .data_a_i(a12_s), .data_b_i(b8_s),
    .valid_o(vd_s), .tag_o(td_s), .data_p_o(pd_s), .sat_o(sd_s));

  multiplier_pipe #(.A_WIDTH(8), .B_WIDTH(8), .TAG_WIDTH(2), .OUT_SHIFT(4),
                    .OUT_WIDTH(8), .ROUND(1)) u_c (
    .clk_i(clk_s), .reset_an_i(rst_an_s), .reset_i(rst_s), .stall_i(stall_s),
    .valid_i(valid_s), .signed_i(sgn_s), .tag_i(tag_s), .data_a_i(a8_s), .data_b_i(b8_s),
    .valid_o(vc_s), .tag_o(tc_s), .data_p_o(pc_s), .sat_o(sc_s));

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total_s++;
    assert (obs === exp) else begin
      bad_s++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_s);
  endtask

  task automatic op(input logic [7:0] a8, input logic [7:0] b8, input logic [11:0] a12,
                    input logic [11:0] b12, input logic sgn, input logic [1:0] tag);
    valid_s = 1'b1;
    a8_s    = a8;
    b8_s    = b8;
    a12_s   = a12;
    b12_s   = b12;
    sgn_s   = sgn;
    tag_s   = tag;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1 rst_an_s = 1'b0;
    #2;
    chk("rst_valid", 32'(va_s), 32'd0);
    chk("rst_tag",   32'(ta_s), 32'd0);
    chk("rst_data",  32'(pa_s), 32'd0);
    chk("rst_sat",   32'(sa_s), 32'd0);
    chk("rst_c_sat", 32'(sc_s), 32'd0);
    cyc();
    rst_an_s = 1'b1;
    cyc();

    // 1: unsigned 255*255, single valid, latency 4
    op(8'd255, 8'd255, 12'd0, 12'd0, 1'b0, 2'd0);
    cyc();
    valid_s = 1'b0;
    cyc();
    cyc();
    chk("t1_early", 32'(va_s), 32'd0);
    cyc();
    chk("t1_valid", 32'(va_s), 32'd1);
    chk("t1_data",  32'(pa_s), 32'd65025);
    chk("t1_sat",   32'(sa_s), 32'd0);
    cyc();
    chk("t1_after", 32'(va_s), 32'd0);

    // 2: signed back-to-back with tags 1,2,3
    op(8'h80, 8'h80, 12'd0, 12'd0, 1'b1, 2'd1);
    cyc();
    op(8'hFF, 8'h7F, 12'd0, 12'd0, 1'b1, 2'd2);
    cyc();
    op(8'h00, 8'hFB, 12'd0, 12'd0, 1'b1, 2'd3);
    cyc();
    valid_s = 1'b0;
    cyc();
    chk("t2_v1", 32'(va_s), 32'd1);
    chk("t2_p1", 32'(pa_s), 32'h4000);
    chk("t2_t1", 32'(ta_s), 32'd1);
    cyc();
    chk("t2_v2", 32'(va_s), 32'd1);
    chk("t2_p2", 32'(pa_s), 32'hFF81);
    chk("t2_t2", 32'(ta_s), 32'd2);
    cyc();
    chk("t2_v3", 32'(va_s), 32'd1);
    chk("t2_p3", 32'(pa_s), 32'h0000);
    chk("t2_t3", 32'(ta_s), 32'd3);
    cyc();
    chk("t2_end", 32'(va_s), 32'd0);

    // 3: unequal widths, both orientations
    op(8'h64, 8'h64, 12'h830, 12'h830, 1'b1, 2'd1);
    cyc();
    op(8'h03, 8'h03, 12'hFFF, 12'hFFF, 1'b0, 2'd2);
    cyc();
    valid_s = 1'b0;
    cyc();
    cyc();
    chk("t3_b_v1", 32'(vb_s), 32'd1);
    chk("t3_b_p1", 32'(pb_s), 32'hCF2C0);
    chk("t3_b_t1", 32'(tb_s), 32'd1);
    chk("t3_b_s1", 32'(sb_s), 32'd0);
    chk("t3_d_v1", 32'(vd_s), 32'd1);
    chk("t3_d_p1", 32'(pd_s), 32'hCF2C0);
    chk("t3_d_t1", 32'(td_s), 32'd1);
    cyc();
    chk("t3_b_p2", 32'(pb_s), 32'd12285);
    chk("t3_b_t2", 32'(tb_s), 32'd2);
    chk("t3_d_p2", 32'(pd_s), 32'd12285);
    chk("t3_d_s2", 32'(sd_s), 32'd0);

    // 4: shift 4, round, saturate to 8 bits
    for (int i = 0; i < 10; i++) begin
      if (i < 7) op(T4_A[i], T4_B[i], 12'd0, 12'd0, T4_S[i], 2'(i));
      else valid_s = 1'b0;
      cyc();
      if (i >= 3) begin
        chk("t4_valid", 32'(vc_s), 32'd1);
        chk("t4_data",  32'(pc_s), 32'(T4_P[i-3]));
        chk("t4_sat",   32'(sc_s), 32'(T4_Q[i-3]));
        chk("t4_tag",   32'(tc_s), 32'((i - 3) & 3));
      end
    end
    cyc();
    chk("t4_end", 32'(vc_s), 32'd0);

    // 5: stall for 3 cycles while results are streaming out
    op(8'd2, 8'd3, 12'd0, 12'd0, 1'b0, 2'd0);
    cyc();
    op(8'd4, 8'd5, 12'd0, 12'd0, 1'b0, 2'd1);
    cyc();
    op(8'd6, 8'd7, 12'd0, 12'd0, 1'b0, 2'd2);
    cyc();
    op(8'd8, 8'd9, 12'd0, 12'd0, 1'b0, 2'd3);
    cyc();
    chk("t5_v1", 32'(va_s), 32'd1);
    chk("t5_p1", 32'(pa_s), 32'd6);
    op(8'd11, 8'd11, 12'd0, 12'd0, 1'b0, 2'd0);
    stall_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_hold_v", 32'(va_s), 32'd1);
      chk("t5_hold_p", 32'(pa_s), 32'd6);
      chk("t5_hold_t", 32'(ta_s), 32'd0);
    end
    stall_s = 1'b0;
    valid_s = 1'b0;
    cyc();
    chk("t5_v2", 32'(va_s), 32'd1);
    chk("t5_p2", 32'(pa_s), 32'd20);
    chk("t5_t2", 32'(ta_s), 32'd1);
    cyc();
    chk("t5_p3", 32'(pa_s), 32'd42);
    chk("t5_t3", 32'(ta_s), 32'd2);
    cyc();
    chk("t5_v4", 32'(va_s), 32'd1);
    chk("t5_p4", 32'(pa_s), 32'd72);
    chk("t5_t4", 32'(ta_s), 32'd3);
    cyc();
    chk("t5_end", 32'(va_s), 32'd0);

    // 6a: synchronous reset (with stall also high) drops 3 in-flight ops
    op(8'd5, 8'd6, 12'd0, 12'd0, 1'b0, 2'd1);
    cyc();
    op(8'd7, 8'd8, 12'd0, 12'd0, 1'b0, 2'd2);
    cyc();
    op(8'd9, 8'd10, 12'd0, 12'd0, 1'b0, 2'd3);
    cyc();
    valid_s = 1'b0;
    rst_s   = 1'b1;
    stall_s = 1'b1;
    cyc();
    chk("t6_srst_v", 32'(va_s), 32'd0);
    chk("t6_srst_p", 32'(pa_s), 32'd0);
    chk("t6_srst_t", 32'(ta_s), 32'd0);
    rst_s   = 1'b0;
    stall_s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t6_srst_idle", 32'(va_s), 32'd0);
    end

    // 6b: asynchronous reset mid-cycle clears outputs at once
    op(8'd3, 8'd3, 12'd0, 12'd0, 1'b0, 2'd1);
    cyc();
    op(8'd4, 8'd4, 12'd0, 12'd0, 1'b0, 2'd2);
    cyc();
    op(8'd5, 8'd5, 12'd0, 12'd0, 1'b0, 2'd3);
    cyc();
    op(8'd6, 8'd6, 12'd0, 12'd0, 1'b0, 2'd0);
    cyc();
    chk("t6_pre_v", 32'(va_s), 32'd1);
    chk("t6_pre_p", 32'(pa_s), 32'd9);
    chk("t6_pre_t", 32'(ta_s), 32'd1);
    valid_s = 1'b0;
    #2 rst_an_s = 1'b0;
    #1;
    chk("t6_arst_v", 32'(va_s), 32'd0);
    chk("t6_arst_p", 32'(pa_s), 32'd0);
    chk("t6_arst_t", 32'(ta_s), 32'd0);
    #1 rst_an_s = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t6_arst_idle", 32'(va_s), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total_s, bad_s);
    $finish;
  end

endmodule
